// File: rtl/ffdiv_operand_decode.sv
// Operand front end for the Goldschmidt divider: capture, classify, normalise.
// Define FFDIV_DEC_1CYC_NORM_EN for single-cycle denormal normalisation.
module ffdiv_operand_decode #(
  parameter int OPERAND_WIDTH     = 32,
  parameter int EXP_WIDTH         = 8,
  parameter int FRACTION_WIDTH    = 23,
  parameter int SIGNIFICAND_WIDTH = 24,
  parameter int UNB_EXP_WIDTH     = 10,
  parameter int BIASING_CONSTANT  = 127
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [OPERAND_WIDTH-1:0]     opa,
  input  logic [OPERAND_WIDTH-1:0]     opb,
  input  logic                         div_ready,
  output logic                         busy,
  output logic                         dec_valid,
  output logic                         sign1,
  output logic                         sign2,
  output logic [SIGNIFICAND_WIDTH-1:0] sgfnd1,
  output logic [SIGNIFICAND_WIDTH-1:0] sgfnd2,
  output logic [UNB_EXP_WIDTH-1:0]     unb_exp1,
  output logic [UNB_EXP_WIDTH-1:0]     unb_exp2,
  output logic                         is_norm1,
  output logic                         is_norm2,
  output logic                         is_denorm1,
  output logic                         is_denorm2,
  output logic [OPERAND_WIDTH-1:0]     res_nan,
  output logic                         res_indet,
  output logic                         res_inf,
  output logic                         res_zero
);

  localparam int MSB  = SIGNIFICAND_WIDTH - 1;
  localparam int QBIT = FRACTION_WIDTH - 1;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
  localparam logic [UNB_EXP_WIDTH-1:0] BIAS =
    UNB_EXP_WIDTH'(BIASING_CONSTANT);
  localparam logic [UNB_EXP_WIDTH-1:0] DEN_EXP =
    UNB_EXP_WIDTH'(1 - BIASING_CONSTANT);

  typedef enum logic [1:0] {
    S_IDLE, S_CLASSIFY, S_NORM, S_VALID
  } state_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic den;
    logic nrm;
  } cls_t;

  typedef struct packed {
    logic                         sign;
    logic [SIGNIFICAND_WIDTH-1:0] sg;
    logic [UNB_EXP_WIDTH-1:0]     ue;
    logic                         nrm;
    logic                         den;
  } opd_t;

  function automatic cls_t classify(
    input logic [OPERAND_WIDTH-1:0] op
  );
    logic [EXP_WIDTH-1:0] e;
    logic                 fz;
    cls_t                 c;
    e  = op[OPERAND_WIDTH-2 -: EXP_WIDTH];
    fz = (op[FRACTION_WIDTH-1:0] == '0);
    c  = '0;
    unique case (1'b1)
      (e == EXP_MAX) && !fz: c.nan  = 1'b1;
      (e == EXP_MAX) &&  fz: c.inf  = 1'b1;
      (e == '0)      &&  fz: c.zero = 1'b1;
      (e == '0)      && !fz: c.den  = 1'b1;
      default:               c.nrm  = 1'b1;
    endcase
    return c;
  endfunction

  function automatic opd_t decode(
    input logic [OPERAND_WIDTH-1:0] op,
    input cls_t                     c
  );
    opd_t d;
    d      = '0;
    d.sign = op[OPERAND_WIDTH-1];
    if (c.nrm) begin
      d.sg  = {1'b1, op[FRACTION_WIDTH-1:0]};
      d.ue  = UNB_EXP_WIDTH'(op[OPERAND_WIDTH-2 -: EXP_WIDTH]) - BIAS;
      d.nrm = 1'b1;
    end else if (c.den) begin
      d.sg  = {1'b0, op[FRACTION_WIDTH-1:0]};
      d.ue  = DEN_EXP;
      d.den = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [OPERAND_WIDTH-1:0] quiet(
    input logic [OPERAND_WIDTH-1:0] op
  );
    logic [OPERAND_WIDTH-1:0] q;
    q       = op;
    q[QBIT] = 1'b1;
    return q;
  endfunction

`ifdef FFDIV_DEC_1CYC_NORM_EN
  function automatic logic [4:0] lzc(
    input logic [SIGNIFICAND_WIDTH-1:0] v
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < SIGNIFICAND_WIDTH; i++)
      if (v[i]) n = 5'(MSB - i);
    return n;
  endfunction

  function automatic opd_t norm_step(input opd_t d);
    opd_t       r;
    logic [4:0] n;
    r = d;
    n = lzc(d.sg);
    if (d.den) begin
      r.sg = d.sg << n;
      r.ue = d.ue - UNB_EXP_WIDTH'(n);
    end
    return r;
  endfunction
`else
  function automatic opd_t norm_step(input opd_t d);
    opd_t r;
    r = d;
    if (d.den && !d.sg[MSB]) begin
      r.sg = d.sg << 1;
      r.ue = d.ue - UNB_EXP_WIDTH'(1);
    end
    return r;
  endfunction
`endif

  state_t                   state_q, state_d;
  logic [OPERAND_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  opd_t                     op1_q, op1_d, op2_q, op2_d;
  logic [OPERAND_WIDTH-1:0] nan_q, nan_d;
  logic                     indet_q, indet_d;
  logic                     inf_q, inf_d;
  logic                     zero_q, zero_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;

  cls_t ca, cb;
  opd_t n1, n2;
  logic any_nan, fin_a, fin_b;
  logic c_indet, c_inf, c_zero;

  assign ca      = classify(opa_q);
  assign cb      = classify(opb_q);
  assign n1      = norm_step(op1_q);
  assign n2      = norm_step(op2_q);
  assign any_nan = ca.nan | cb.nan;
  assign fin_a   = !(ca.nan | ca.inf);
  assign fin_b   = !(cb.nan | cb.inf);
  // Priority order keeps the special-result flags mutually exclusive.
  assign c_indet = !any_nan &&
                   ((ca.zero && cb.zero) || (ca.inf && cb.inf));
  assign c_inf   = !any_nan && !c_indet &&
                   ((ca.inf && fin_b) || (fin_a && cb.zero));
  assign c_zero  = !any_nan && !c_indet && !c_inf &&
                   ((ca.zero && fin_b && !cb.zero) ||
                    (fin_a && cb.inf));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    nan_d   = nan_q;
    indet_d = indet_q;
    inf_d   = inf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = opa;
          opb_d   = opb;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        op1_d   = decode(opa_q, ca);
        op2_d   = decode(opb_q, cb);
        nan_d   = ca.nan ? quiet(opa_q) :
                  cb.nan ? quiet(opb_q) : '0;
        indet_d = c_indet;
        inf_d   = c_inf;
        zero_d  = c_zero;
        state_d = (ca.den | cb.den) ? S_NORM : S_VALID;
      end
      S_NORM: begin
        op1_d = n1;
        op2_d = n2;
        if ((!n1.den || n1.sg[MSB]) && (!n2.den || n2.sg[MSB]))
          state_d = S_VALID;
      end
      S_VALID: begin
        if (valid_q && div_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_q == S_VALID) && !(valid_q && div_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      nan_q   <= '0;
      indet_q <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      nan_q   <= nan_d;
      indet_q <= indet_d;
      inf_q   <= inf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy       = busy_q;
  assign dec_valid  = valid_q;
  assign sign1      = op1_q.sign;
  assign sign2      = op2_q.sign;
  assign sgfnd1     = op1_q.sg;
  assign sgfnd2     = op2_q.sg;
  assign unb_exp1   = op1_q.ue;
  assign unb_exp2   = op2_q.ue;
  assign is_norm1   = op1_q.nrm;
  assign is_norm2   = op2_q.nrm;
  assign is_denorm1 = op1_q.den;
  assign is_denorm2 = op2_q.den;
  assign res_nan    = nan_q;
  assign res_indet  = indet_q;
  assign res_inf    = inf_q;
  assign res_zero   = zero_q;

endmodule
